// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 writeback path.
// Flag indices address the 5-bit sticky {NV,DZ,OF,UF,NX} form.
package fma16_pkg;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [15:0] CANON_NAN_H = 16'h7E00;

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  flags;
    } fma16_res_t;

    // Exponent all ones with a non-zero mantissa; infinities are excluded.
    function automatic logic is_nan16(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
    endfunction

endpackage

// File: rtl/fma16_wb_fifo.sv
// Generic 2-entry FIFO with valid/ready on both sides.
// Ready and valid come straight from the occupancy register, so there is no
// combinational path from out_ready_i to in_ready_o.
module fma16_wb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         push;
    logic         pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rptr_q];

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= in_data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fma16_wb.sv
// Writeback stage after the fma16 datapath: buffers result+tag, canonicalises
// NaNs on write, accumulates sticky fflags and counts retired results.
module fma16_wb
    import fma16_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int CANON_NAN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clr,
    input  logic             fflags_we,
    input  logic [4:0]       fflags_wdata,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = $bits(fma16_res_t) + TAG_W;

    fma16_res_t        wr_res;
    fma16_res_t        rd_res;
    logic [PW-1:0]     wr_data;
    logic [PW-1:0]     rd_data;
    logic              accept;
    logic              retire;
    logic [4:0]        acc_flags;
    logic [4:0]        fflags_q;
    logic [4:0]        fflags_d;
    logic [CNT_W-1:0]  op_count_q;

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    always_comb begin
        wr_res.flags  = in_flags;
        wr_res.result = in_result;
        if ((CANON_NAN != 0) && is_nan16(in_result)) begin
            wr_res.result = CANON_NAN_H;
        end
    end

    assign wr_data = {wr_res, in_tag};

    fma16_wb_fifo #(
        .W (PW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (wr_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (rd_data)
    );

    assign rd_res     = rd_data[PW-1:TAG_W];
    assign out_result = rd_res.result;
    assign out_flags  = rd_res.flags;
    assign out_tag    = rd_data[TAG_W-1:0];

    // Accepted flags are OR'd in on every branch so a coincident clear or
    // software write can never lose them.
    always_comb begin
        acc_flags = 5'd0;
        if (accept) begin
            acc_flags[FLG_NV] = in_flags[3];
            acc_flags[FLG_OF] = in_flags[2];
            acc_flags[FLG_UF] = in_flags[1];
            acc_flags[FLG_NX] = in_flags[0];
        end
        if (fflags_we) begin
            fflags_d = fflags_wdata | acc_flags;
        end else if (fflags_clr) begin
            fflags_d = acc_flags;
        end else begin
            fflags_d = fflags_q | acc_flags;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fflags_q   <= 5'd0;
            op_count_q <= '0;
        end else begin
            fflags_q <= fflags_d;
            if (retire) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign fflags   = fflags_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_fma16_wb.sv
// Directed bench for fma16_wb: a vector table for pass-through/NaN handling,
// then hand-written backpressure, sticky-flag, async reset and wrap sequences.
module tb_fma16_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic        fflags_clr;
    logic        fflags_we;
    logic [4:0]  fflags_wdata;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [15:0] out_result, out_result2;
    logic [3:0]  out_flags, out_flags2;
    logic [3:0]  out_tag, out_tag2;
    logic [4:0]  fflags, fflags2;
    logic [15:0] op_count;
    logic [3:0]  op_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fma16_wb #(.TAG_W(4), .CANON_NAN(1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_tag(out_tag),
        .fflags(fflags), .fflags_clr(fflags_clr), .fflags_we(fflags_we),
        .fflags_wdata(fflags_wdata), .op_count(op_count)
    );

    fma16_wb #(.TAG_W(4), .CANON_NAN(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_result(in_result),
        .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_flags(out_flags2), .out_tag(out_tag2),
        .fflags(fflags2), .fflags_clr(fflags_clr), .fflags_we(fflags_we),
        .fflags_wdata(fflags_wdata), .op_count(op_count2)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle push; returns at the following negedge with inputs idle.
    task automatic push(input logic [15:0] res, input logic [3:0] flg, input logic [3:0] tag,
                        input logic clr, input logic we, input logic [4:0] wd);
        in_valid     = 1'b1;
        in_result    = res;
        in_flags     = flg;
        in_tag       = tag;
        fflags_clr   = clr;
        fflags_we    = we;
        fflags_wdata = wd;
        @(negedge clk);
        in_valid     = 1'b0;
        fflags_clr   = 1'b0;
        fflags_we    = 1'b0;
        fflags_wdata = 5'd0;
    endtask

    initial begin
        logic [4:0] exp_ff;

        vecs[0] = '{16'h3C00, 4'b0000, 4'h1, 16'h3C00};
        vecs[1] = '{16'h7C01, 4'b1000, 4'h2, 16'h7E00};
        vecs[2] = '{16'hFD55, 4'b1000, 4'h3, 16'h7E00};
        vecs[3] = '{16'h7C00, 4'b0000, 4'h4, 16'h7C00};
        vecs[4] = '{16'hFC00, 4'b0101, 4'h5, 16'hFC00};
        vecs[5] = '{16'h7FFF, 4'b1001, 4'h6, 16'h7E00};
        vecs[6] = '{16'h0001, 4'b0011, 4'h7, 16'h0001};
        vecs[7] = '{16'h7BFF, 4'b0100, 4'h8, 16'h7BFF};

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_result    = 16'h0;
        in_flags     = 4'h0;
        in_tag       = 4'h0;
        out_ready    = 1'b0;
        fflags_clr   = 1'b0;
        fflags_we    = 1'b0;
        fflags_wdata = 5'd0;

        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_result", 32'(out_result), 32'h0);
        chk("rst out_flags", 32'(out_flags), 32'h0);
        chk("rst out_tag", 32'(out_tag), 32'h0);
        chk("rst fflags", 32'(fflags), 32'h0);
        chk("rst op_count", 32'(op_count), 32'd0);
        reset_n = 1'b1;

        // Table: each entry visible one cycle after accept, retired the next.
        out_ready = 1'b1;
        exp_ff = 5'd0;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_result = vecs[i].res;
            in_flags  = vecs[i].flg;
            in_tag    = vecs[i].tag;
            exp_ff    = exp_ff | {vecs[i].flg[3], 1'b0, vecs[i].flg[2:0]};
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d out_result", i), 32'(out_result), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d out_flags", i), 32'(out_flags), 32'(vecs[i].flg));
            chk($sformatf("v%0d out_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d raw result", i), 32'(out_result2), 32'(vecs[i].res));
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d op_count", i), 32'(op_count), 32'(i + 1));
            chk($sformatf("v%0d drained", i), 32'(out_valid), 32'd0);
        end
        chk("table fflags", 32'(fflags), 32'(exp_ff));

        // Backpressure: fill, hold tag 3, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'h1111; in_flags = 4'h0; in_tag = 4'h1;
        @(negedge clk);
        chk("bp in_ready 1", 32'(in_ready), 32'd1);
        chk("bp head 1", 32'(out_tag), 32'h1);
        in_tag = 4'h2; in_result = 16'h2222;
        @(negedge clk);
        chk("bp full", 32'(in_ready), 32'd0);
        in_tag = 4'h3; in_result = 16'h3333;
        @(negedge clk);
        chk("bp hold", 32'(in_ready), 32'd0);
        chk("bp hold head", 32'(out_tag), 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp retire 1 head", 32'(out_tag), 32'h2);
        chk("bp reopen", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp head 3", 32'(out_tag), 32'h3);
        chk("bp result 3", 32'(out_result), 32'h3333);
        chk("bp count1", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp empty", 32'(out_valid), 32'd0);
        chk("bp op_count", 32'(op_count), 32'd11);

        // Sticky flags.
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        chk("clr alone", 32'(fflags), 32'h00);
        push(16'h4000, 4'b0001, 4'h9, 1'b0, 1'b0, 5'd0);
        chk("sticky NX", 32'(fflags), 32'b00001);
        push(16'h4000, 4'b1000, 4'hA, 1'b0, 1'b0, 5'd0);
        chk("sticky NV|NX", 32'(fflags), 32'b10001);
        push(16'h4000, 4'b0100, 4'hB, 1'b1, 1'b0, 5'd0);
        chk("clr+accept OF", 32'(fflags), 32'b00100);
        push(16'h4000, 4'b0001, 4'hC, 1'b0, 1'b1, 5'b01000);
        chk("we+accept", 32'(fflags), 32'b01001);
        @(negedge clk);

        // Async reset with two entries buffered.
        out_ready = 1'b0;
        push(16'h5555, 4'h1, 4'h5, 1'b0, 1'b0, 5'd0);
        push(16'h6666, 4'h2, 4'h6, 1'b0, 1'b0, 5'd0);
        chk("pre-rst full", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst fflags", 32'(fflags), 32'd0);
        chk("arst op_count", 32'(op_count), 32'd0);
        chk("arst op_count2", 32'(op_count2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst empty", 32'(out_valid), 32'd0);

        // Streaming 16 retires: FIFO order each cycle, 4-bit counter wraps.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid  = 1'b1;
            in_tag    = 4'(k);
            in_result = 16'(k);
            in_flags  = 4'h0;
            @(negedge clk);
            chk($sformatf("stream tag %0d", k), 32'(out_tag), 32'(k));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream op_count", 32'(op_count), 32'd16);
        chk("wrap op_count2", 32'(op_count2), 32'd0);
        chk("stream empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma16_wb.md
Name: fma16_wb

Overview:
- Writeback/result stage directly downstream of the combinational fma16 datapath.
- Registers each fma16 result together with its tag in a 2-entry buffer, with a valid/ready handshake on both sides.
- Canonicalises NaN results.
- Accumulates sticky IEEE exception flags (fflags) and counts retired operations for the consumer (register file / test harness).

Parameters:
- TAG_W, 4, width of the operation tag carried alongside each result.
- CANON_NAN, 1, when 1 every NaN result is replaced by 16'h7E00.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fma16 result and flags are valid this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- in_result  in  16  fma16 result.
- in_flags  in  4  fma16 flags {NV,OF,UF,NX}.
- in_tag  in  TAG_W  tag of the operation.
- out_valid  out  1  buffered result available.
- out_ready  in  1  consumer accepts the head entry.
- out_result  out  16  head result, canonicalised.
- out_flags  out  4  head entry flags.
- out_tag  out  TAG_W  head entry tag.
- fflags  out  5  sticky {NV,DZ,OF,UF,NX}; DZ is always 0 for FMA.
- fflags_clr  in  1  clear sticky flags.
- fflags_we  in  1  software write of sticky flags.
- fflags_wdata  in  5  write data for sticky flags.
- op_count  out  CNT_W  number of retired results (output handshakes).

Behaviour:
- Reset (reset_n=0, asynchronous): buffer empty; out_valid=0; in_ready=1; out_result/out_flags/out_tag=0; fflags=0; op_count=0.
- A reset asserted mid-operation discards buffered entries immediately.
- Buffer: 2-entry FIFO with write pointer, read pointer and count[1:0] (values 0..2).
  - in_ready = (count != 2), driven from registers only.
  - out_valid = (count != 0), driven from registers only.
- Accept = in_valid & in_ready. Retire = out_valid & out_ready.
- Latency: a result accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty.
- Full buffer plus simultaneous retire: in_ready stays 0 that cycle (no combinational ready path). The entry is accepted next cycle.
- Simultaneous accept and retire with count=1: count stays 1, and the head advances to the new entry.
- While count=0, out_result, out_flags and out_tag hold their last value and are don't-care.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- NaN canonicalisation is applied at buffer write:
  - Condition: in_result[14:10]==5'h1F and in_result[9:0]!=0.
  - When CANON_NAN=1, the stored result is 16'h7E00 with sign 0.
  - Infinities (mantissa 0) pass through unchanged.
  - Flags are never modified.
- fflags next-state priority:
  - fflags_we: fflags = fflags_wdata | accept-flags.
  - else fflags_clr: fflags = accept-flags.
  - else: fflags = fflags | accept-flags.
- accept-flags = {in_flags[3], 1'b0, in_flags[2:0]} when Accept, otherwise 0.
- Flags are committed at Accept time, so an accepted result's flags are never lost to a coincident clear.
- op_count increments by 1 on each Retire and wraps from 2^CNT_W-1 to 0 without saturating.
- Input stability: in_* must hold while in_valid=1 and in_ready=0. The stage does not check this.
- All state is in always_ff blocks with async reset. Outputs are registered or driven directly from registered state.

Decomposition:
- Shared package fma16_pkg holds:
  - flag bit-index constants (FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0 for the 5-bit form);
  - CANON_NAN_H = 16'h7E00;
  - the typedef fma16_res_t = struct {logic [15:0] result; logic [3:0] flags;}.
- One sub-module: fma16_wb_fifo, a generic 2-entry FIFO parameterised on payload width.
- NaN detection, fflags and the counter stay in fma16_wb.

Test Plan:
- Single pass-through: in 3C00, flags 0, tag 1 at cycle 0 with out_ready=1 -> out_valid=1 at cycle 1 with 3C00, tag 1; op_count=1 at cycle 2.
- Backpressure: out_ready=0, push tags 1,2,3 -> in_ready drops to 0 after the 2nd accept; tag 3 is held; out_ready=1 -> tags retire in order 1,2,3; op_count=3.
- NaN canonicalisation: in_result 7C01 and then FD55 -> out_result 7E00 both times; 7C00 passes as 7C00; with CANON_NAN=0, 7C01 passes unchanged.
- Sticky flags: accept flags 4'b0001, then 4'b1000 -> fflags=5'b10001; fflags_clr together with accept of 4'b0100 -> fflags=5'b00100.
- fflags_we=1, wdata 5'b01000, plus accept of 4'b0001 in the same cycle -> fflags=5'b01001.
- Reset mid-stream: two entries buffered, reset_n pulsed low asynchronously between clock edges -> out_valid=0, in_ready=1, fflags=0 and op_count=0 immediately; a CNT_W=4 wrap run of 16 retires returns op_count to 0.
